// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor pattern history table.
package branch_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'b00;
    localparam ctr_t CTR_WNT   = 2'b01;
    localparam ctr_t CTR_WT    = 2'b10;
    localparam ctr_t CTR_ST    = 2'b11;
    localparam ctr_t CTR_RESET = CTR_WNT;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Saturating two-bit counter step toward the resolved direction.
    function automatic ctr_t ctr_train(input ctr_t c, input logic taken);
        case (c)
            CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
            default: return taken ? CTR_ST  : CTR_WT;
        endcase
    endfunction

endpackage

// File: rtl/branch_pht_ram.sv
// Simple dual-port counter storage: synchronous read-first read port, one write port.
module pht_ram
    import branch_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [INDEX_BITS-1:0] rd_addr,
    output ctr_t                  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_addr,
    input  ctr_t                  wr_data
);

    ctr_t mem [2 ** INDEX_BITS];

    // NOTE: the array has no reset so it can map onto block RAM; the owner sweeps it instead.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/branch_pht.sv
// Pattern history table of two-bit counters with a reset-time init sweep.
// Define BRANCH_PHT_GSHARE_EN to XOR the index with a global history register.
module branch_pht
    import branch_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_in,
    input  logic                  lookup_en,
    output logic                  prediction,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  update_en,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  actual_taken,
    output logic                  ready
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    typedef logic [INDEX_BITS-1:0] idx_t;

    state_t state_q, state_d;
    idx_t   init_cnt;
    logic   in_init;
    logic   upd_go;
    idx_t   lk_idx;
    logic   pc_unused;

    // Update pipeline: read at the update edge, write-back one edge later.
    logic   s1_v, s1_taken;
    idx_t   s1_idx;
    ctr_t   upd_rd, upd_cur, upd_next;
    logic   last_w_v;
    idx_t   last_w_idx;
    ctr_t   last_w_ctr;

    logic   wr_en;
    idx_t   wr_addr;
    ctr_t   wr_data;

    logic   lk_fresh, lk_run, pred_q, lk_taken, lk_ctr_unused;
    ctr_t   lk_rd, lk_ctr;

    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_hist_check
        $error("branch_pht: HIST_BITS must be in 1..INDEX_BITS");
    end

    assign pc_unused = ^{pc_in[31:INDEX_BITS+2], pc_in[1:0]};
    assign upd_go    = update_en & (state_q == ST_RUN);

`ifdef BRANCH_PHT_GSHARE_EN
    logic [HIST_BITS-1:0] ghr;

    assign lk_idx = pc_in[INDEX_BITS+1:2] ^ idx_t'(ghr);

    // Non-speculative history; the lookup above hashes the pre-shift value.
    always_ff @(posedge clk) begin
        if (reset)       ghr <= '0;
        else if (upd_go) ghr <= HIST_BITS'({ghr, actual_taken});
    end
`else
    assign lk_idx = pc_in[INDEX_BITS+1:2];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_cnt == idx_t'(ENTRIES - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        in_init = (state_q == ST_INIT);
        ready   = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset)        init_cnt <= '0;
        else if (in_init) init_cnt <= init_cnt + idx_t'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v       <= 1'b0;
            s1_idx     <= '0;
            s1_taken   <= 1'b0;
            last_w_v   <= 1'b0;
            last_w_idx <= '0;
            last_w_ctr <= CTR_RESET;
        end else begin
            s1_v       <= upd_go;
            s1_idx     <= update_index;
            s1_taken   <= actual_taken;
            last_w_v   <= s1_v;
            last_w_idx <= s1_idx;
            last_w_ctr <= upd_next;
        end
    end

    // The RAM is read-first, so the previous edge's write must be forwarded.
    assign upd_cur  = (last_w_v && last_w_idx == s1_idx) ? last_w_ctr : upd_rd;
    assign upd_next = ctr_train(upd_cur, s1_taken);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_idx;
        wr_data = upd_next;
        if (!reset) begin
            if (in_init) begin
                wr_en   = 1'b1;
                wr_addr = init_cnt;
                wr_data = CTR_RESET;
            end else begin
                wr_en = s1_v;
            end
        end
    end

    // Two identical copies give lookup and update their own read port.
    pht_ram #(.INDEX_BITS(INDEX_BITS)) u_lk_ram (
        .clk     (clk),
        .rd_en   (lookup_en),
        .rd_addr (lk_idx),
        .rd_data (lk_rd),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    pht_ram #(.INDEX_BITS(INDEX_BITS)) u_upd_ram (
        .clk     (clk),
        .rd_en   (upd_go),
        .rd_addr (update_index),
        .rd_data (upd_rd),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Newest counter for the looked-up entry: same-edge update wins, then last write, then RAM.
    always_comb begin
        lk_ctr = lk_rd;
        if (s1_v && s1_idx == pred_index)              lk_ctr = upd_next;
        else if (last_w_v && last_w_idx == pred_index) lk_ctr = last_w_ctr;
    end

    assign lk_taken      = lk_run & lk_ctr[1];
    assign lk_ctr_unused = lk_ctr[0];
    assign prediction    = lk_fresh ? lk_taken : pred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lk_fresh   <= 1'b0;
            lk_run     <= 1'b0;
            pred_q     <= 1'b0;
            pred_index <= '0;
        end else begin
            lk_fresh <= lookup_en;
            lk_run   <= ~in_init;
            if (lk_fresh)  pred_q     <= lk_taken;
            if (lookup_en) pred_index <= lk_idx;
        end
    end

endmodule
